frame_fetch: RTL and testbench

FRAME_FETCH -- requirements
Module: frame_fetch

---
 rtl/frame_pkg.sv | 14 +
 rtl/frame_fifo.sv | 53 +++++
 rtl/frame_fetch.sv | 115 +++++++++++
 tb/tb_frame_fetch.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/frame_pkg.sv
// Shared types for the frame fetch path: fetch FSM encoding and word/pixel geometry.
package frame_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_DISCARD = 2'd2
  } fetch_state_t;

  localparam int NIBBLES_PER_WORD = 4;
  localparam int WORD_W           = 16;
  localparam int PIX_W            = 4;

endpackage

// File: rtl/frame_fifo.sv
// Word FIFO between memory fetch and pixel unpacking; head is visible combinationally.
// Push/pop in the same cycle both apply; flush wins over both. Caller never pushes when full.
module frame_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_dat,
  input  logic                       pop,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [WIDTH-1:0]           head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset: count gates every use of the head word.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_dat;
  end

  assign count = cnt;
  assign head  = mem[rd_ptr];

endmodule

// File: rtl/frame_fetch.sv
// Prefetches frame words from memory (one request outstanding) and unpacks them LSB-nibble first.
// Request rises one edge after reset release; data is visible the cycle after ack; underrun is sticky.
module frame_fetch
  import frame_pkg::*;
#(
  parameter int FRAME_WORDS = 4800,
  parameter int ADDR_W      = 16,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_next_pixel_in,
  input  logic              frame_reset_in,
  output logic [PIX_W-1:0]  frame_pixel_out,
  output logic              mem_req_out,
  output logic [ADDR_W-1:0] mem_addr_out,
  input  logic              mem_ack_in,
  input  logic [WORD_W-1:0] mem_data_in,
  output logic              underrun_out
);

  localparam int                CNT_W     = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);
  localparam logic [1:0]        LAST_IDX  = 2'(NIBBLES_PER_WORD - 1);

  fetch_state_t      state;
  logic [ADDR_W-1:0] addr;
  logic              req;
  logic [1:0]        idx;
  logic              underrun;
  logic [CNT_W-1:0]  count;
  logic [WORD_W-1:0] head;
  logic              empty;
  logic              push;
  logic              pop;

  assign empty = (count == '0);
  assign push  = (state == ST_REQ) && mem_ack_in && !frame_reset_in;
  assign pop   = frame_next_pixel_in && !frame_reset_in && !empty && (idx == LAST_IDX);

  frame_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_dat (mem_data_in),
    .pop      (pop),
    .flush    (frame_reset_in),
    .count    (count),
    .head     (head)
  );

  // The address is held through DISCARD so the in-flight request stays stable;
  // it is zeroed when that request's ack finally arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      req   <= 1'b0;
      addr  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (frame_reset_in) begin
            addr <= '0;
          end else if (count < CNT_W'(FIFO_DEPTH)) begin
            state <= ST_REQ;
            req   <= 1'b1;
          end
        end
        ST_REQ: begin
          if (mem_ack_in) begin
            state <= ST_IDLE;
            req   <= 1'b0;
            addr  <= (frame_reset_in || addr == LAST_ADDR) ? '0 : addr + ADDR_W'(1);
          end else if (frame_reset_in) begin
            state <= ST_DISCARD;
          end
        end
        ST_DISCARD: begin
          if (mem_ack_in) begin
            state <= ST_IDLE;
            req   <= 1'b0;
            addr  <= '0;
          end
        end
        default: begin
          state <= ST_IDLE;
          req   <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= '0;
      underrun <= 1'b0;
    end else if (frame_reset_in) begin
      idx      <= '0;
      underrun <= 1'b0;
    end else if (frame_next_pixel_in) begin
      if (empty)      underrun <= 1'b1;
      else if (pop)   idx      <= '0;
      else            idx      <= idx + 2'd1;
    end
  end

  assign frame_pixel_out = empty ? '0 : head[{idx, 2'b00} +: PIX_W];
  assign mem_req_out     = req;
  assign mem_addr_out    = addr;
  assign underrun_out    = underrun;

endmodule

// File: tb/tb_frame_fetch.sv
// Directed bench for frame_fetch: table of frame words with hand-unpacked pixels plus corner sequences.
module tb_frame_fetch;

  localparam int FRAME_WORDS = 8;
  localparam int ADDR_W      = 16;
  localparam int FIFO_DEPTH  = 4;

  typedef struct {
    logic [15:0] word;
    logic [3:0]  p0, p1, p2, p3;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              frame_next_pixel_in = 1'b0;
  logic              frame_reset_in = 1'b0;
  logic [3:0]        frame_pixel_out;
  logic              mem_req_out;
  logic [ADDR_W-1:0] mem_addr_out;
  logic              mem_ack_in = 1'b0;
  logic [15:0]       mem_data_in = '0;
  logic              underrun_out;

  vec_t              vec [FRAME_WORDS];
  logic [ADDR_W-1:0] req_log [$];
  logic              ack_en = 1'b0;
  logic [ADDR_W-1:0] stop_addr = 16'hFFFF;
  logic              prev_req = 1'b0;
  logic [ADDR_W-1:0] prev_addr = '0;
  int                addr_unstable = 0;
  int                tests = 0;
  int                failed = 0;

  frame_fetch #(
    .FRAME_WORDS (FRAME_WORDS),
    .ADDR_W      (ADDR_W),
    .FIFO_DEPTH  (FIFO_DEPTH)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .frame_next_pixel_in (frame_next_pixel_in),
    .frame_reset_in      (frame_reset_in),
    .frame_pixel_out     (frame_pixel_out),
    .mem_req_out         (mem_req_out),
    .mem_addr_out        (mem_addr_out),
    .mem_ack_in          (mem_ack_in),
    .mem_data_in         (mem_data_in),
    .underrun_out        (underrun_out)
  );

  always #5 clk = ~clk;

  // Memory model: acks one cycle after it sees a request, unless disabled or the address is blocked.
  always @(posedge clk) begin
    #2;
    if (mem_ack_in) begin
      mem_ack_in = 1'b0;
    end else if (rst_n && ack_en && mem_req_out && mem_addr_out != stop_addr) begin
      mem_ack_in  = 1'b1;
      mem_data_in = vec[mem_addr_out[2:0]].word;
      req_log.push_back(mem_addr_out);
    end
    if (mem_req_out && prev_req && mem_addr_out != prev_addr) addr_unstable++;
    prev_req  = mem_req_out;
    prev_addr = mem_addr_out;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_next();
    frame_next_pixel_in = 1'b1;
    tick();
    frame_next_pixel_in = 1'b0;
  endtask

  task automatic pulse_reset();
    frame_reset_in = 1'b1;
    tick();
    frame_reset_in = 1'b0;
  endtask

  function automatic logic [3:0] nib(input vec_t v, input int n);
    case (n)
      0:       return v.p0;
      1:       return v.p1;
      2:       return v.p2;
      default: return v.p3;
    endcase
  endfunction

  initial begin
    int   log_n;
    logic seen_f;

    vec[0] = '{16'h4321, 4'h1, 4'h2, 4'h3, 4'h4};
    vec[1] = '{16'hA5F0, 4'h0, 4'hF, 4'h5, 4'hA};
    vec[2] = '{16'h0001, 4'h1, 4'h0, 4'h0, 4'h0};
    vec[3] = '{16'h8000, 4'h0, 4'h0, 4'h0, 4'h8};
    vec[4] = '{16'h1234, 4'h4, 4'h3, 4'h2, 4'h1};
    vec[5] = '{16'hFFFF, 4'hF, 4'hF, 4'hF, 4'hF};
    vec[6] = '{16'h0F0F, 4'hF, 4'h0, 4'hF, 4'h0};
    vec[7] = '{16'hC3B2, 4'h2, 4'hB, 4'h3, 4'hC};

    // Reset state
    tick();
    tick();
    check("rst_req", mem_req_out, 0);
    check("rst_addr", mem_addr_out, 0);
    check("rst_pix", frame_pixel_out, 0);
    check("rst_underrun", underrun_out, 0);

    // First request one edge after release, then fill to depth
    rst_n = 1'b1;
    tick();
    check("first_req", mem_req_out, 1);
    check("first_addr", mem_addr_out, 0);
    ack_en = 1'b1;
    repeat (12) tick();
    check("fill_log_size", req_log.size(), 4);
    for (int i = 0; i < 4 && i < req_log.size(); i++)
      check($sformatf("fill_addr%0d", i), req_log[i], i);
    check("full_no_req", mem_req_out, 0);

    // Continuous consumption across the address wrap
    for (int w = 0; w < 10; w++)
      for (int n = 0; n < 4; n++) begin
        check($sformatf("pix_w%0d_n%0d", w, n), frame_pixel_out, nib(vec[w % FRAME_WORDS], n));
        pulse_next();
      end
    check("stream_log_size", req_log.size() >= 10, 1);
    for (int i = 0; i < 10 && i < req_log.size(); i++)
      check($sformatf("stream_addr%0d", i), req_log[i], i % FRAME_WORDS);
    check("stream_no_underrun", underrun_out, 0);

    // Underrun with memory stalled
    ack_en = 1'b0;
    repeat (3) tick();
    pulse_reset();
    check("flush_pix", frame_pixel_out, 0);
    check("flush_underrun", underrun_out, 0);
    pulse_next();
    pulse_next();
    check("underrun_set", underrun_out, 1);
    check("underrun_pix", frame_pixel_out, 0);
    pulse_reset();
    check("underrun_cleared", underrun_out, 0);

    // Asynchronous reset while a request is pending
    tick();
    check("pending_req", mem_req_out, 1);
    rst_n = 1'b0;
    #1;
    check("async_req_drop", mem_req_out, 0);
    check("async_addr", mem_addr_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("rerelease_req", mem_req_out, 1);
    check("rerelease_addr", mem_addr_out, 0);

    // Frame reset while the request for address 5 is stalled
    stop_addr = 16'd5;
    ack_en    = 1'b1;
    repeat (10) tick();
    for (int w = 0; w < 2; w++)
      for (int n = 0; n < 4; n++) begin
        check($sformatf("pre_pix_w%0d_n%0d", w, n), frame_pixel_out, nib(vec[w], n));
        pulse_next();
      end
    repeat (3) tick();
    check("stall_req", mem_req_out, 1);
    check("stall_addr", mem_addr_out, 5);
    pulse_reset();
    check("discard_req_held", mem_req_out, 1);
    check("discard_addr_held", mem_addr_out, 5);
    check("discard_pix", frame_pixel_out, 0);
    log_n = req_log.size();
    tick();
    stop_addr = 16'hFFFF;
    seen_f = 1'b0;
    repeat (12) begin
      tick();
      if (frame_pixel_out == 4'hF) seen_f = 1'b1;
    end
    check("dropped_never_shown", seen_f, 0);
    check("post_discard_log_size", req_log.size() >= log_n + 2, 1);
    if (req_log.size() >= log_n + 2) begin
      check("discarded_addr", req_log[log_n], 5);
      check("restart_addr", req_log[log_n + 1], 0);
    end
    check("restart_pix", frame_pixel_out, 4'h1);
    check("addr_stable", addr_unstable, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
